// File: rtl/ram_word_unloader_if.sv
// Control, basic_ram read port and byte-stream signals of ram_word_unloader.
// master = the unloader; slave = the RAM/sink/controller side.
interface ram_word_unloader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_oe;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, base_addr, word_count, mem_rdata, mem_done, out_ready,
    output busy, done, mem_addr, mem_cs, mem_we, mem_oe, out_byte, out_valid, out_last
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, mem_done, out_ready,
    input  busy, done, mem_addr, mem_cs, mem_we, mem_oe, out_byte, out_valid, out_last
  );
endinterface

// File: rtl/ram_word_unloader.sv
// Reads a block of 32-bit words from basic_ram and streams each as four bytes,
// most significant byte first, on a valid/ready byte interface.
module ram_word_unloader #(
  parameter int unsigned ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  ram_word_unloader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StEmit, StFin} state_e;

  localparam logic [ADDR_W-1:0] One = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [31:0]       word_q;
  logic [1:0]        idx_q;
  logic              busy_q;
  logic              done_q;
  logic              cs_q;
  logic              oe_q;
  logic              valid_q;
  logic              last_q;
  logic [7:0]        byte_q;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_q        <= 1'b0;
      oe_q        <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      byte_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            addr_q      <= bus.base_addr;
            remaining_q <= bus.word_count;
            if (bus.word_count == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRead;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              oe_q    <= 1'b1;
            end
          end
        end

        StRead: begin
          if (bus.mem_done) begin
            word_q  <= bus.mem_rdata;
            idx_q   <= 2'd0;
            byte_q  <= bus.mem_rdata[31:24];
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            state_q <= StEmit;
          end
        end

        StEmit: begin
          if (valid_q && bus.out_ready) begin
            if (idx_q == 2'd3) begin
              remaining_q <= remaining_q - One;
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
              byte_q      <= '0;
              if (remaining_q == One) begin
                state_q <= StFin;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                // Address wraps silently at 2^ADDR_W.
                addr_q  <= addr_q + One;
                cs_q    <= 1'b1;
                oe_q    <= 1'b1;
                state_q <= StRead;
              end
            end else begin
              idx_q  <= idx_q + 2'd1;
              byte_q <= byte_sel(word_q, idx_q + 2'd1);
              last_q <= (idx_q == 2'd2) && (remaining_q == One);
            end
          end
        end

        StFin: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_oe    = oe_q;
  assign bus.mem_we    = 1'b0;
  assign bus.out_byte  = byte_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_ram_word_unloader.sv
// Bench for ram_word_unloader: a byte-queue model built from RAM contents is checked
// every cycle, with directed scenarios and literal expectations pinning the model.
module tb_ram_word_unloader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_word_unloader_if #(.ADDR_W(32)) bus ();
  ram_word_unloader #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  ram_word_unloader_if #(.ADDR_W(4)) bus4 ();
  ram_word_unloader #(.ADDR_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM and sink models
  logic [31:0] mem  [8];
  logic [31:0] mem4 [16];
  int mem_delay = 0;  // 0: mem_done tied high; N: done on the Nth cycle of a read
  int cs_cnt = 0;
  int ready_mode = 0;
  int tick = 0;
  logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cs_cnt <= bus.mem_cs ? cs_cnt + 1 : 0;

  assign bus.mem_rdata  = mem[bus.mem_addr[2:0]];
  assign bus.mem_done   = (mem_delay == 0) ? 1'b1 : (bus.mem_cs && (cs_cnt == mem_delay - 1));
  assign bus4.mem_rdata = mem4[bus4.mem_addr];
  assign bus4.mem_done  = 1'b1;
  assign bus4.out_ready = 1'b1;

  always @(posedge clk) begin
    #1;
    tick++;
    bus.out_ready = (ready_mode == 0) ? 1'b1 : rdy_pat[tick % 4];
  end

  // Reference model: expected byte stream and read addresses
  logic [8:0]  exp_q [$];
  logic [31:0] exp_addr;
  logic [7:0]  got_q [$];
  logic [31:0] rd_q [$];
  int          run_q [$];
  int hs_cnt = 0, done_cnt = 0, cs_seen = 0, valid_seen = 0, cs_run = 0;
  logic prev_valid = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_byte = '0;
  logic [8:0] exp_e;

  task automatic build_model(input logic [31:0] base, input logic [31:0] cnt);
    logic [31:0] w;
    exp_q.delete();
    exp_addr = base;
    for (int i = 0; i < int'(cnt); i++) begin
      w = mem[(base + i) & 7];
      for (int b = 0; b < 4; b++)
        exp_q.push_back({(i == int'(cnt) - 1) && (b == 3), w[31 - 8*b -: 8]});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      cs_run     = 0;
    end else begin
      chk("mem_we", bus.mem_we, 1'b0);
      if (bus.mem_cs) begin
        cs_seen++;
        cs_run++;
        chk("rd_addr", bus.mem_addr, exp_addr);
        chk("mem_oe", bus.mem_oe, 1'b1);
        chk("valid_in_read", bus.out_valid, 1'b0);
        chk("busy_read", bus.busy, 1'b1);
        if (bus.mem_done) begin
          rd_q.push_back(bus.mem_addr);
          run_q.push_back(cs_run);
          exp_addr = exp_addr + 1;
          cs_run   = 0;
        end
      end else begin
        chk("mem_oe_idle", bus.mem_oe, 1'b0);
        cs_run = 0;
      end
      if (bus.out_valid) begin
        valid_seen++;
        chk("busy_emit", bus.busy, 1'b1);
        if (prev_valid && !prev_hs) begin
          chk("hold_byte", bus.out_byte, prev_byte);
          chk("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_ready) begin
          hs_cnt++;
          got_q.push_back(bus.out_byte);
          if (exp_q.size() == 0) begin
            chk("extra_byte", 64'(exp_q.size()), 64'd1);
          end else begin
            exp_e = exp_q.pop_front();
            chk("out_byte", bus.out_byte, exp_e[7:0]);
            chk("out_last", bus.out_last, exp_e[8]);
          end
        end
      end else if (prev_valid && !prev_hs) begin
        chk("valid_drop", bus.out_valid, 1'b1);
      end
      if (bus.done) done_cnt++;
      prev_valid = bus.out_valid;
      prev_hs    = bus.out_valid && bus.out_ready;
      prev_byte  = bus.out_byte;
      prev_last  = bus.out_last;
    end
  end

  task automatic run_dump(input logic [31:0] base, input logic [31:0] cnt, input int poke,
                          output int cyc);
    int d0;
    d0 = done_cnt;
    got_q.delete();
    rd_q.delete();
    run_q.delete();
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = (cyc == poke);
      if (cyc == poke) begin
        bus.base_addr  = 32'h5;
        bus.word_count = 32'h1;
      end
    end while (!bus.done && cyc < 1000);
    bus.start = 1'b0;
    chk("done_seen", bus.done, 1'b1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.done, 1'b0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_cs"}, bus.mem_cs, 1'b0);
    chk({tag, "_mem_oe"}, bus.mem_oe, 1'b0);
    chk({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_byte"}, bus.out_byte, 8'h0);
    chk({tag, "_out_last"}, bus.out_last, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask

  logic [7:0] basic_exp [12] = '{8'hE3, 8'hA0, 8'h00, 8'h01, 8'hE2, 8'h80, 8'h00, 8'h02,
                                 8'hEA, 8'hFF, 8'hFF, 8'hFE};
  logic [7:0] wrap_exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hB6, 8'hC7, 8'hD8};

  task automatic check_basic_bytes(input string tag);
    chk({tag, "_nbytes"}, 64'(got_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], basic_exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, h0, d0, c0, v0;
    logic [7:0] got4 [$];
    logic [3:0] addr4 [$];
    logic [7:0] last4;

    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem4[i] = '0;
    mem[0] = 32'hE3A00001;
    mem[1] = 32'hE2800002;
    mem[2] = 32'hEAFFFFFE;
    mem[3] = 32'h0BADF00D;
    mem4[15] = 32'h11223344;
    mem4[0]  = 32'hA5B6C7D8;

    rst = 1'b1;
    bus.start = 1'b0;  bus.base_addr = '0;  bus.word_count = '0;
    bus4.start = 1'b0; bus4.base_addr = '0; bus4.word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic dump, with literal pins on the model queue
    build_model(32'h0, 32'd3);
    chk("model_size", 64'(exp_q.size()), 64'd12);
    chk("model_first", exp_q[0], 9'h0E3);
    chk("model_last", exp_q[11], 9'h1FE);
    chk("model_mid", exp_q[5], 9'h080);
    run_dump(32'h0, 32'd3, 0, cyc);
    chk("basic_done_latency", 64'(cyc), 64'd16);
    check_basic_bytes("basic");
    chk("basic_reads", 64'(rd_q.size()), 64'd3);

    // Backpressure: ready pattern 1,0,0,1
    ready_mode = 1;
    build_model(32'h0, 32'd3);
    run_dump(32'h0, 32'd3, 0, cyc);
    check_basic_bytes("bp");
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Slow memory: mem_done on the 7th read cycle
    mem_delay = 7;
    build_model(32'h0, 32'd3);
    run_dump(32'h0, 32'd3, 0, cyc);
    check_basic_bytes("slow");
    chk("slow_nreads", 64'(run_q.size()), 64'd3);
    for (int i = 0; i < run_q.size(); i++) chk("slow_cs_len", 64'(run_q[i]), 64'd7);
    for (int i = 0; i < rd_q.size(); i++) chk("slow_rd_addr", rd_q[i], 32'(i));
    chk("slow_done_latency", 64'(cyc), 64'd34);
    mem_delay = 0;

    // Zero count
    c0 = cs_seen;
    v0 = valid_seen;
    build_model(32'h0, 32'd0);
    run_dump(32'h2, 32'd0, 0, cyc);
    chk("zero_done_latency", 64'(cyc), 64'd1);
    chk("zero_no_cs", 64'(cs_seen - c0), 64'd0);
    chk("zero_no_valid", 64'(valid_seen - v0), 64'd0);

    // Start pulsed while busy is ignored
    build_model(32'h0, 32'd3);
    run_dump(32'h0, 32'd3, 4, cyc);
    check_basic_bytes("ignstart");
    chk("ignstart_latency", 64'(cyc), 64'd16);

    // Reset in the middle of word 2 of a 4-word dump
    build_model(32'h0, 32'd4);
    h0 = hs_cnt;
    bus.start = 1'b1;
    bus.base_addr = 32'h0;
    bus.word_count = 32'd4;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      bus.start = 1'b0;
    end while (hs_cnt - h0 < 9 && cyc < 200);
    chk("rst_reached_word2", 64'(hs_cnt - h0), 64'd9);
    chk("rst_pre_valid", bus.out_valid, 1'b1);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_idle_valid", bus.out_valid, 1'b0);
    build_model(32'h0, 32'd1);
    run_dump(32'h0, 32'd1, 0, cyc);
    chk("restart_latency", 64'(cyc), 64'd6);
    chk("restart_nbytes", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("restart_byte", got_q[i], basic_exp[i]);

    // Address wrap on the 4-bit instance
    last4 = '0;
    bus4.start = 1'b1;
    bus4.base_addr = 4'hF;
    bus4.word_count = 4'd2;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    cyc = 0;
    while (!bus4.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus4.mem_cs && bus4.mem_done) addr4.push_back(bus4.mem_addr);
      if (bus4.out_valid && bus4.out_ready) begin
        if (got4.size() < 8) last4[got4.size()] = bus4.out_last;
        got4.push_back(bus4.out_byte);
      end
    end
    chk("wrap_done", bus4.done, 1'b1);
    chk("wrap_nreads", 64'(addr4.size()), 64'd2);
    if (addr4.size() == 2) begin
      chk("wrap_addr0", addr4[0], 4'hF);
      chk("wrap_addr1", addr4[1], 4'h0);
    end
    chk("wrap_nbytes", 64'(got4.size()), 64'd8);
    for (int i = 0; i < 8 && i < got4.size(); i++) chk("wrap_byte", got4[i], wrap_exp[i]);
    chk("wrap_last_mask", last4, 8'h80);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
